// File: rtl/i2c_slave_regmap_pkg.sv
// Shared constants for the I2C register-map controller: FSM state encodings
// and the default power-on register value.
package i2c_slave_regmap_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_PTR  = 2'd1;
    localparam state_t ST_DATA = 2'd2;

    localparam logic [7:0] DEFAULT_RESET_VALUE = 8'h00;

endpackage

// File: rtl/i2c_slave_regmap_if.sv
// Byte-stream link between the I2C slave PHY (master modport) and the
// register-map controller (slave modport).
interface i2c_slave_regmap_if;

    logic       i2c_start;
    logic       i2c_stop;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_req;
    logic [7:0] tx_data;

    modport master (
        output i2c_start,
        output i2c_stop,
        output rx_data,
        output rx_valid,
        output tx_req,
        input  tx_data
    );

    modport slave (
        input  i2c_start,
        input  i2c_stop,
        input  rx_data,
        input  rx_valid,
        input  tx_req,
        output tx_data
    );

endinterface

// File: rtl/i2c_slave_regmap_edge_rise.sv
// One-bit rising-edge detector: a level held high produces a single pulse.
module edge_rise (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk) begin
        if (!reset) begin
            prev <= 1'b0;
        end else begin
            prev <= din;
        end
    end

    assign rise = din & ~prev;

endmodule

// File: rtl/i2c_slave_regmap.sv
// Pointer-addressed register bank shared between an I2C slave byte stream and
// a local host port. Define I2C_REGMAP_RO_EN to make indices >= RO_BASE I2C-read-only.
module i2c_slave_regmap
    import i2c_slave_regmap_pkg::*;
#(
    parameter int         REG_COUNT   = 16,
    parameter logic [7:0] RESET_VALUE = DEFAULT_RESET_VALUE,
    parameter int         RO_BASE     = REG_COUNT / 2,
    localparam int        PW          = $clog2(REG_COUNT)
) (
    input  logic                clk,
    input  logic                reset,
    i2c_slave_regmap_if.slave   bus,
    input  logic                loc_we,
    input  logic [PW-1:0]       loc_addr,
    input  logic [7:0]          loc_wdata,
    output logic [7:0]          loc_rdata,
    output logic                wr_strobe,
    output logic [PW-1:0]       wr_addr,
    output logic                collision,
    output logic [PW-1:0]       ptr
);

`ifdef I2C_REGMAP_RO_EN
    localparam bit RO_EN = 1'b1;
`else
    localparam bit RO_EN = 1'b0;
`endif

    state_t        state;
    state_t        state_next;
    logic [PW-1:0] ptr_next;
    logic [7:0]    regs [REG_COUNT];

    logic rx_ev;
    logic tx_ev;
    logic rx_act;
    logic i2c_writable;
    logic i2c_we;

    edge_rise u_rx_edge (
        .clk   (clk),
        .reset (reset),
        .din   (bus.rx_valid),
        .rise  (rx_ev)
    );

    edge_rise u_tx_edge (
        .clk   (clk),
        .reset (reset),
        .din   (bus.tx_req),
        .rise  (tx_ev)
    );

    // A byte arriving in the same cycle as START/STOP belongs to no transfer.
    assign rx_act       = rx_ev && !bus.i2c_start && !bus.i2c_stop;
    assign i2c_writable = !RO_EN || (int'(ptr) < RO_BASE);
    assign i2c_we       = rx_act && (state == ST_DATA) && i2c_writable;

    always_comb begin
        state_next = state;
        if (bus.i2c_stop) begin
            state_next = ST_IDLE;
        end else if (bus.i2c_start) begin
            state_next = ST_PTR;
        end else if (rx_ev && state == ST_PTR) begin
            state_next = ST_DATA;
        end
    end

    // RX takes precedence over TX; dropped read-only writes still advance ptr.
    always_comb begin
        ptr_next = ptr;
        if (rx_ev) begin
            if (rx_act && state == ST_PTR) begin
                ptr_next = bus.rx_data[PW-1:0];
            end else if (rx_act && state == ST_DATA) begin
                ptr_next = ptr + PW'(1);
            end
        end else if (tx_ev) begin
            ptr_next = ptr + PW'(1);
        end
    end

    // Two write ports per register, so the bank is kept as discrete flops.
    for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_reg
        always_ff @(posedge clk) begin
            if (!reset) begin
                regs[gi] <= RESET_VALUE;
            end else if (i2c_we && ptr == PW'(gi)) begin
                regs[gi] <= bus.rx_data;
            end else if (loc_we && loc_addr == PW'(gi)) begin
                regs[gi] <= loc_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            bus.tx_data <= RESET_VALUE;
            loc_rdata   <= RESET_VALUE;
            wr_strobe   <= 1'b0;
            wr_addr     <= '0;
            collision   <= 1'b0;
        end else begin
            state       <= state_next;
            ptr         <= ptr_next;
            bus.tx_data <= regs[ptr_next];
            loc_rdata   <= regs[loc_addr];
            wr_strobe   <= i2c_we;
            if (i2c_we) begin
                wr_addr <= ptr;
            end
            collision   <= i2c_we && loc_we && (loc_addr == ptr);
        end
    end

endmodule

// File: tb/tb_i2c_slave_regmap.sv
// Directed bench for i2c_slave_regmap: a per-cycle vector table plus hand
// sequences for reset, read-only indices and mid-transfer reset.
module tb_i2c_slave_regmap;

`ifdef I2C_REGMAP_RO_EN
    localparam bit RO = 1'b1;
`else
    localparam bit RO = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       loc_we;
    logic [3:0] loc_addr;
    logic [7:0] loc_wdata;
    logic [7:0] loc_rdata;
    logic       wr_strobe;
    logic [3:0] wr_addr;
    logic       collision;
    logic [3:0] ptr;

    i2c_slave_regmap_if bus ();

    i2c_slave_regmap #(
        .REG_COUNT   (16),
        .RESET_VALUE (8'h00),
        .RO_BASE     (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .loc_we    (loc_we),
        .loc_addr  (loc_addr),
        .loc_wdata (loc_wdata),
        .loc_rdata (loc_rdata),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .collision (collision),
        .ptr       (ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       st, sp, rv;
        logic [7:0] rd;
        logic       tr, lw;
        logic [3:0] la;
        logic [7:0] lwd;
        logic       e_str;
        logic [3:0] e_wa;
        logic       e_col;
        logic [3:0] e_ptr;
        logic       c_rd;
        logic [7:0] e_rd;
        logic       c_tx;
        logic [7:0] e_tx;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic add(input int st, input int sp, input int rv, input int rd,
                       input int tr, input int lw, input int la, input int lwd,
                       input int es, input int ewa, input int ec, input int ep,
                       input int crd, input int erd, input int ctx, input int etx);
        vec_t v;
        v.st = 1'(st);   v.sp = 1'(sp);   v.rv = 1'(rv);   v.rd = 8'(rd);
        v.tr = 1'(tr);   v.lw = 1'(lw);   v.la = 4'(la);   v.lwd = 8'(lwd);
        v.e_str = 1'(es); v.e_wa = 4'(ewa); v.e_col = 1'(ec); v.e_ptr = 4'(ep);
        v.c_rd = 1'(crd); v.e_rd = 8'(erd); v.c_tx = 1'(ctx); v.e_tx = 8'(etx);
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input int st, input int sp, input int rv, input int rd,
                         input int tr, input int lw, input int la, input int lwd);
        bus.i2c_start = 1'(st);
        bus.i2c_stop  = 1'(sp);
        bus.rx_valid  = 1'(rv);
        bus.rx_data   = 8'(rd);
        bus.tx_req    = 1'(tr);
        loc_we        = 1'(lw);
        loc_addr      = 4'(la);
        loc_wdata     = 8'(lwd);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check("rst_ptr",       0, 32'(ptr), 0);
        check("rst_tx_data",   0, 32'(bus.tx_data), 0);
        check("rst_loc_rdata", 0, 32'(loc_rdata), 0);
        check("rst_wr_strobe", 0, 32'(wr_strobe), 0);
        check("rst_wr_addr",   0, 32'(wr_addr), 0);
        check("rst_collision", 0, 32'(collision), 0);
        $display("reset: ptr=%0h tx_data=%0h loc_rdata=%0h", ptr, bus.tx_data, loc_rdata);
        reset = 1'b1;

        //  st sp rv rd    tr lw la lwd    str wa col ptr  crd rd  ctx tx
        // write sequence: pointer 3, then A5, 5A
        add(1,0,0,'h00, 0,0,0,'h00,  0,0,0,0,  0,0,0,0);
        add(0,0,1,'h03, 0,0,0,'h00,  0,0,0,3,  0,0,0,0);
        add(0,0,0,'h00, 0,0,0,'h00,  0,0,0,3,  0,0,0,0);
        add(0,0,1,'hA5, 0,0,0,'h00,  1,3,0,4,  0,0,0,0);
        add(0,0,0,'h00, 0,0,0,'h00,  0,0,0,4,  0,0,0,0);
        add(0,0,1,'h5A, 0,0,0,'h00,  1,4,0,5,  0,0,0,0);
        add(0,0,0,'h00, 0,0,3,'h00,  0,0,0,5,  1,'hA5,0,0);
        add(0,1,0,'h00, 0,0,4,'h00,  0,0,0,5,  1,'h5A,0,0);
        // RX in IDLE is ignored
        add(0,0,1,'h99, 0,0,0,'h00,  0,0,0,5,  0,0,0,0);
        add(0,0,0,'h00, 0,0,5,'h00,  0,0,0,5,  1,'h00,0,0);
        // START and STOP together: STOP wins, following byte ignored
        add(1,1,0,'h00, 0,0,0,'h00,  0,0,0,5,  0,0,0,0);
        add(0,0,1,'h66, 0,0,0,'h00,  0,0,0,5,  0,0,0,0);
        add(0,0,0,'h00, 0,0,0,'h00,  0,0,0,5,  0,0,0,0);
        // pointer wrap 15 -> 0
        add(1,0,0,'h00, 0,0,0,'h00,  0,0,0,5,  0,0,0,0);
        add(0,0,1,'h0F, 0,0,0,'h00,  0,0,0,15, 0,0,0,0);
        add(0,0,0,'h00, 0,0,0,'h00,  0,0,0,15, 0,0,0,0);
        add(0,0,1,'h11, 0,0,0,'h00,  RO?0:1,15,0,0, 0,0,0,0);
        add(0,0,0,'h00, 0,0,0,'h00,  0,0,0,0,  0,0,0,0);
        add(0,0,1,'h22, 0,0,0,'h00,  1,0,0,1,  0,0,0,0);
        add(0,0,0,'h00, 0,0,15,'h00, 0,0,0,1,  1,RO?'h00:'h11,0,0);
        add(0,1,0,'h00, 0,0,0,'h00,  0,0,0,1,  1,'h22,0,0);
        // rx_valid held high five cycles: one write only
        add(1,0,0,'h00, 0,0,0,'h00,  0,0,0,1,  0,0,0,0);
        add(0,0,1,'h00, 0,0,0,'h00,  0,0,0,0,  0,0,0,0);
        add(0,0,0,'h00, 0,0,0,'h00,  0,0,0,0,  0,0,0,0);
        add(0,0,1,'h77, 0,0,0,'h00,  1,0,0,1,  0,0,0,0);
        add(0,0,1,'h77, 0,0,0,'h00,  0,0,0,1,  0,0,0,0);
        add(0,0,1,'h77, 0,0,0,'h00,  0,0,0,1,  0,0,0,0);
        add(0,0,1,'h77, 0,0,0,'h00,  0,0,0,1,  0,0,0,0);
        add(0,0,1,'h77, 0,0,0,'h00,  0,0,0,1,  0,0,0,0);
        add(0,1,0,'h00, 0,0,0,'h00,  0,0,0,1,  1,'h77,0,0);
        // collision at index 6
        add(1,0,0,'h00, 0,0,0,'h00,  0,0,0,1,  0,0,0,0);
        add(0,0,1,'h06, 0,0,0,'h00,  0,0,0,6,  0,0,0,0);
        add(0,0,0,'h00, 0,0,0,'h00,  0,0,0,6,  0,0,0,0);
        add(0,0,1,'h42, 0,1,6,'hFF,  1,6,1,7,  0,0,0,0);
        add(0,0,0,'h00, 0,0,6,'h00,  0,0,0,7,  1,'h42,0,0);
        // I2C to 6 and local to 7 in the same cycle: both land
        add(1,0,0,'h00, 0,0,0,'h00,  0,0,0,7,  0,0,0,0);
        add(0,0,1,'h06, 0,0,0,'h00,  0,0,0,6,  0,0,0,0);
        add(0,0,0,'h00, 0,0,0,'h00,  0,0,0,6,  0,0,0,0);
        add(0,0,1,'h55, 0,1,7,'hFF,  1,6,0,7,  0,0,0,0);
        add(0,0,0,'h00, 0,0,6,'h00,  0,0,0,7,  1,'h55,0,0);
        add(0,1,0,'h00, 0,0,7,'h00,  0,0,0,7,  1,'hFF,0,0);
        // read stream from pointer 2 after repeated START
        add(0,0,0,'h00, 0,1,2,'hC3,  0,0,0,7,  0,0,0,0);
        add(0,0,0,'h00, 0,1,3,'h3C,  0,0,0,7,  0,0,0,0);
        add(1,0,0,'h00, 0,0,0,'h00,  0,0,0,7,  0,0,0,0);
        add(0,0,1,'h02, 0,0,0,'h00,  0,0,0,2,  0,0,1,'hC3);
        add(0,0,0,'h00, 0,0,0,'h00,  0,0,0,2,  0,0,1,'hC3);
        add(1,0,0,'h00, 0,0,0,'h00,  0,0,0,2,  0,0,1,'hC3);
        add(0,0,0,'h00, 1,0,0,'h00,  0,0,0,3,  0,0,1,'h3C);
        add(0,0,0,'h00, 1,0,0,'h00,  0,0,0,3,  0,0,1,'h3C);
        add(0,0,0,'h00, 0,0,0,'h00,  0,0,0,3,  0,0,1,'h3C);
        add(0,0,0,'h00, 1,0,0,'h00,  0,0,0,4,  0,0,1,'h5A);
        add(0,1,0,'h00, 0,0,0,'h00,  0,0,0,4,  0,0,1,'h5A);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].st, vecs[i].sp, vecs[i].rv, vecs[i].rd,
                  vecs[i].tr, vecs[i].lw, vecs[i].la, vecs[i].lwd);
            check("ptr",       i, 32'(ptr), 32'(vecs[i].e_ptr));
            check("wr_strobe", i, 32'(wr_strobe), 32'(vecs[i].e_str));
            check("collision", i, 32'(collision), 32'(vecs[i].e_col));
            if (vecs[i].e_str) check("wr_addr", i, 32'(wr_addr), 32'(vecs[i].e_wa));
            if (vecs[i].c_rd)  check("loc_rdata", i, 32'(loc_rdata), 32'(vecs[i].e_rd));
            if (vecs[i].c_tx)  check("tx_data", i, 32'(bus.tx_data), 32'(vecs[i].e_tx));
            $display("vec %0d: ptr=%0h wr_strobe=%0b wr_addr=%0h collision=%0b loc_rdata=%0h tx_data=%0h",
                     i, ptr, wr_strobe, wr_addr, collision, loc_rdata, bus.tx_data);
        end

        // index 8: read-only to I2C when the feature is built in, writable otherwise
        drive(1, 0, 0, 'h00, 0, 0, 0, 'h00);
        drive(0, 0, 1, 'h08, 0, 0, 0, 'h00);
        check("ro_ptr_set", 100, 32'(ptr), 8);
        drive(0, 0, 0, 'h00, 0, 0, 0, 'h00);
        drive(0, 0, 1, 'hAB, 0, 0, 0, 'h00);
        check("ro_wr_strobe", 101, 32'(wr_strobe), RO ? 0 : 1);
        check("ro_ptr_inc",   101, 32'(ptr), 9);
        check("ro_collision", 101, 32'(collision), 0);
        drive(0, 0, 0, 'h00, 0, 0, 8, 'h00);
        check("ro_reg8", 102, 32'(loc_rdata), RO ? 32'h00 : 32'hAB);
        $display("ro: reg8 after I2C write=%0h ptr=%0h", loc_rdata, ptr);
        drive(0, 1, 0, 'h00, 0, 1, 8, 'hCD);
        drive(0, 0, 0, 'h00, 0, 0, 8, 'h00);
        check("loc_reg8", 103, 32'(loc_rdata), 32'hCD);
        $display("ro: reg8 after local write=%0h", loc_rdata);

        // reset in the middle of a write transfer
        drive(1, 0, 0, 'h00, 0, 0, 0, 'h00);
        drive(0, 0, 1, 'h03, 0, 0, 0, 'h00);
        drive(0, 0, 0, 'h00, 0, 0, 0, 'h00);
        drive(0, 0, 1, 'hEE, 0, 0, 3, 'h00);
        check("mid_wr_strobe", 104, 32'(wr_strobe), 1);
        reset = 1'b0;
        drive(0, 0, 0, 'h00, 0, 0, 3, 'h00);
        check("mid_rst_ptr",    105, 32'(ptr), 0);
        check("mid_rst_strobe", 105, 32'(wr_strobe), 0);
        check("mid_rst_tx",     105, 32'(bus.tx_data), 0);
        reset = 1'b1;
        drive(0, 0, 0, 'h00, 0, 0, 3, 'h00);
        check("mid_rst_reg3", 106, 32'(loc_rdata), 0);
        drive(0, 0, 1, 'h05, 0, 0, 0, 'h00);
        check("mid_idle_ptr",    107, 32'(ptr), 0);
        check("mid_idle_strobe", 107, 32'(wr_strobe), 0);
        $display("mid reset: ptr=%0h reg3=%0h", ptr, loc_rdata);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
